// File: rtl/duty_ramp.sv
// Soft-start / direction-change sequencer feeding the pwm duty_cycle/en load interface.
// Slews duty toward the commanded target and brakes to zero with a dead interval before any reversal.
module duty_ramp #(
    parameter int                   STEP_BITS   = 17,
    parameter logic [STEP_BITS-1:0] STEP_CYCLES = 17'd100_000,
    parameter logic [6:0]           STEP_SIZE   = 7'd1,
    parameter logic [7:0]           DEAD_STEPS  = 8'd10,
    parameter logic [6:0]           MAX_DUTY    = 7'd100
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [6:0] cmd_duty,
    input  logic       cmd_dir,
    input  logic       e_stop,
    output logic [6:0] duty_cycle,
    output logic       en,
    output logic       dir,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, RAMP, BRAKE, DEAD} state_t;

    localparam logic [STEP_BITS-1:0] STEP_LAST = STEP_CYCLES - 1'b1;

    state_t               state, state_nx;
    logic [STEP_BITS-1:0] step_cnt;
    logic [6:0]           target, target_nx, duty_nx;
    logic                 tdir, tdir_nx, dir_nx;
    logic [7:0]           dead_cnt, dead_nx, dead_inc;
    logic                 tick, accept;
    logic [6:0]           cmd_clamped, ramp_val, brake_val;
    logic [7:0]           duty_up, down_floor;

    assign tick        = (step_cnt == STEP_LAST);
    assign cmd_ready   = !e_stop && (state == IDLE || state == RAMP);
    assign accept      = cmd_valid && cmd_ready;
    assign busy        = (state != IDLE);
    assign cmd_clamped = (cmd_duty > MAX_DUTY) ? MAX_DUTY : cmd_duty;
    assign dead_inc    = dead_cnt + 8'd1;

    // Widened to 8 bits so duty + STEP_SIZE cannot wrap before the clamp.
    assign duty_up    = {1'b0, duty_cycle} + {1'b0, STEP_SIZE};
    assign down_floor = {1'b0, target} + {1'b0, STEP_SIZE};

    always_comb begin
        if (duty_cycle < target)
            ramp_val = (duty_up > {1'b0, target}) ? target : duty_up[6:0];
        else
            ramp_val = ({1'b0, duty_cycle} >= down_floor) ? duty_cycle - STEP_SIZE : target;
        brake_val = (duty_cycle >= STEP_SIZE) ? duty_cycle - STEP_SIZE : 7'd0;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nx  = state;
        duty_nx   = duty_cycle;
        target_nx = target;
        tdir_nx   = tdir;
        dir_nx    = dir;
        dead_nx   = dead_cnt;
        if (e_stop) begin
            state_nx  = IDLE;
            duty_nx   = 7'd0;
            target_nx = 7'd0;
        end else begin
            case (state)
                IDLE, RAMP: begin
                    // An accepted command takes the cycle; a coincident tick is dropped.
                    if (accept) begin
                        target_nx = cmd_clamped;
                        tdir_nx   = cmd_dir;
                        if (cmd_dir != dir)              state_nx = BRAKE;
                        else if (cmd_clamped != duty_cycle) state_nx = RAMP;
                        else                             state_nx = IDLE;
                    end else if (state == RAMP && tick) begin
                        duty_nx = ramp_val;
                        if (ramp_val == target) state_nx = IDLE;
                    end
                end
                BRAKE: if (tick) begin
                    duty_nx = brake_val;
                    if (brake_val == 7'd0) begin
                        state_nx = DEAD;
                        dead_nx  = 8'd0;
                    end
                end
                DEAD: if (tick) begin
                    dead_nx = dead_inc;
                    if (dead_inc >= DEAD_STEPS) begin
                        dir_nx   = tdir;
                        state_nx = (target != 7'd0) ? RAMP : IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
        if (clr) begin
            state      <= IDLE;
            duty_cycle <= 7'd0;
            target     <= 7'd0;
            tdir       <= 1'b0;
            dir        <= 1'b0;
            en         <= 1'b0;
            step_cnt   <= '0;
            dead_cnt   <= 8'd0;
        end else begin
            state      <= state_nx;
            duty_cycle <= duty_nx;
            target     <= target_nx;
            tdir       <= tdir_nx;
            dir        <= dir_nx;
            en         <= (duty_nx != duty_cycle);
            step_cnt   <= tick ? '0 : step_cnt + 1'b1;
            dead_cnt   <= dead_nx;
        end
    end

endmodule

// File: tb/tb_duty_ramp.sv
// Self-checking bench for duty_ramp: expected duty values are queued with each command and
// popped on every en strobe; scenario tasks add inline checks on handshake, timing and dir.
module tb_duty_ramp;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_dir = 1'b0;
    logic       e_stop = 1'b0;
    logic [6:0] cmd_duty = 7'd0;
    logic       cmd_ready, en, dir, busy;
    logic [6:0] duty_cycle;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         dir_cyc = 0;
    int         tcnt = 0;
    logic       prev_dir = 1'b0;
    logic [6:0] exp_q[$];
    int         en_cycles[$];

    duty_ramp #(
        .STEP_BITS(17), .STEP_CYCLES(17'd4), .STEP_SIZE(7'd10),
        .DEAD_STEPS(8'd2), .MAX_DUTY(7'd100)
    ) dut (
        .clk(clk), .clr(clr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_duty(cmd_duty), .cmd_dir(cmd_dir), .e_stop(e_stop),
        .duty_cycle(duty_cycle), .en(en), .dir(dir), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference step timer: tick is active during cycles where tcnt == 3.
    always @(posedge clk) tcnt <= clr ? 0 : ((tcnt == 3) ? 0 : tcnt + 1);

    // Scoreboard monitor: every en strobe must match the next queued duty value.
    always @(posedge clk) begin
        logic [6:0] exp_d;
        #1;
        cyc++;
        if (en === 1'b1) begin
            en_cycles.push_back(cyc);
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_en: en=1 duty=%0d with nothing queued (cycle %0d)", duty_cycle, cyc);
            end else begin
                exp_d = exp_q.pop_front();
                if (duty_cycle !== exp_d) begin
                    n_bad++;
                    $display("FAIL en_duty: duty_cycle=%0d required %0d (cycle %0d)", duty_cycle, exp_d, cyc);
                end
            end
        end
        if (!clr && dir !== prev_dir) begin
            dir_cyc = cyc;
            n_cmp++;
            if (duty_cycle !== 7'd0) begin
                n_bad++;
                $display("FAIL dir_change_duty: duty_cycle=%0d at dir change, required 0", duty_cycle);
            end
        end
        prev_dir = dir;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr = 1'b1; cmd_valid = 1'b0; e_stop = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        step();
    endtask

    task automatic send_cmd(input logic [6:0] d, input logic di, input bit align);
        @(negedge clk);
        if (align) while (tcnt != 3) @(negedge clk);
        cmd_duty = d; cmd_dir = di; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy !== 1'b0 && n < 300) begin step(); n++; end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_timeout: busy=%b after %0d cycles, required 0", name, busy, n);
        end
    endtask

    task automatic wait_duty(input logic [6:0] v, input string name);
        int n = 0;
        while (duty_cycle !== v && n < 200) begin step(); n++; end
        n_cmp++;
        if (duty_cycle !== v) begin
            n_bad++;
            $display("FAIL %s_timeout: duty_cycle=%0d required %0d", name, duty_cycle, v);
        end
    endtask

    task automatic check_drained(input string name);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s_drained: %0d expected en strobes missing, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp += 5;
        if (duty_cycle !== 7'd0) begin n_bad++; $display("FAIL reset_duty: got %0d required 0", duty_cycle); end
        if (dir !== 1'b0)        begin n_bad++; $display("FAIL reset_dir: got %b required 0", dir); end
        if (en !== 1'b0)         begin n_bad++; $display("FAIL reset_en: got %b required 0", en); end
        if (cmd_ready !== 1'b1)  begin n_bad++; $display("FAIL reset_ready: got %b required 1", cmd_ready); end
        if (busy !== 1'b0)       begin n_bad++; $display("FAIL reset_busy: got %b required 0", busy); end
    endtask

    task automatic test_ramp_up();
        en_cycles.delete();
        exp_q.push_back(7'd10); exp_q.push_back(7'd20); exp_q.push_back(7'd30); exp_q.push_back(7'd35);
        send_cmd(7'd35, 1'b0, 1'b0);
        wait_idle("ramp_up");
        n_cmp++;
        if (duty_cycle !== 7'd35) begin n_bad++; $display("FAIL ramp_busy_drop: duty=%0d when busy fell, required 35", duty_cycle); end
        check_drained("ramp_up");
        n_cmp++;
        if (en_cycles.size() != 4) begin n_bad++; $display("FAIL ramp_en_count: got %0d required 4", en_cycles.size()); end
        for (int i = 1; i < en_cycles.size(); i++) begin
            n_cmp++;
            if (en_cycles[i] - en_cycles[i-1] != 4) begin
                n_bad++;
                $display("FAIL ramp_interval: en spacing %0d cycles, required 4", en_cycles[i] - en_cycles[i-1]);
            end
        end
    endtask

    task automatic test_clamp_noop();
        for (int v = 45; v <= 95; v += 10) exp_q.push_back(7'(v));
        exp_q.push_back(7'd100);
        send_cmd(7'd120, 1'b0, 1'b0);
        wait_idle("clamp");
        n_cmp++;
        if (duty_cycle !== 7'd100) begin n_bad++; $display("FAIL clamp_final: got %0d required 100", duty_cycle); end
        check_drained("clamp");
        en_cycles.delete();
        send_cmd(7'd100, 1'b0, 1'b0);
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL noop_busy: got %b required 0", busy); end
        repeat (10) step();
        n_cmp += 2;
        if (duty_cycle !== 7'd100) begin n_bad++; $display("FAIL noop_duty: got %0d required 100", duty_cycle); end
        if (en_cycles.size() != 0) begin n_bad++; $display("FAIL noop_en: got %0d strobes required 0", en_cycles.size()); end
    endtask

    task automatic test_reversal();
        int n = 0;
        int ready_hi = 0;
        for (int v = 90; v >= 30; v -= 10) exp_q.push_back(7'(v));
        send_cmd(7'd30, 1'b0, 1'b0);
        wait_idle("rev_prep");
        check_drained("rev_prep");
        en_cycles.delete();
        exp_q.push_back(7'd20); exp_q.push_back(7'd10); exp_q.push_back(7'd0);
        exp_q.push_back(7'd10); exp_q.push_back(7'd20);
        send_cmd(7'd20, 1'b1, 1'b0);
        while (dir !== 1'b1 && n < 200) begin
            if (cmd_ready !== 1'b0) ready_hi++;
            step(); n++;
        end
        n_cmp += 3;
        if (ready_hi != 0) begin n_bad++; $display("FAIL rev_ready_low: cmd_ready high for %0d cycles in BRAKE/DEAD, required 0", ready_hi); end
        if (dir !== 1'b1)  begin n_bad++; $display("FAIL rev_dir_flip: dir=%b required 1", dir); end
        if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rev_ready_ramp: got %b required 1", cmd_ready); end
        n_cmp++;
        if (en_cycles.size() < 3) begin
            n_bad++; $display("FAIL rev_brake_steps: got %0d strobes before flip, required 3", en_cycles.size());
        end else if (dir_cyc - en_cycles[2] != 8) begin
            n_bad++; $display("FAIL rev_dead_time: flip %0d cycles after duty 0, required 8", dir_cyc - en_cycles[2]);
        end
        wait_idle("reversal");
        n_cmp += 2;
        if (duty_cycle !== 7'd20) begin n_bad++; $display("FAIL rev_final_duty: got %0d required 20", duty_cycle); end
        if (dir !== 1'b1)         begin n_bad++; $display("FAIL rev_final_dir: got %b required 1", dir); end
        check_drained("reversal");
    endtask

    task automatic test_retarget();
        int acc_cyc;
        do_reset();
        exp_q.push_back(7'd10); exp_q.push_back(7'd20); exp_q.push_back(7'd30);
        send_cmd(7'd50, 1'b0, 1'b0);
        wait_duty(7'd30, "retarget_prep");
        en_cycles.delete();
        exp_q.push_back(7'd20); exp_q.push_back(7'd15);
        send_cmd(7'd15, 1'b0, 1'b1);
        acc_cyc = cyc;
        n_cmp += 2;
        if (duty_cycle !== 7'd30) begin n_bad++; $display("FAIL retarget_tick_drop: duty=%0d required 30", duty_cycle); end
        if (en !== 1'b0)          begin n_bad++; $display("FAIL retarget_no_en: en=%b required 0", en); end
        wait_idle("retarget");
        n_cmp++;
        if (duty_cycle !== 7'd15) begin n_bad++; $display("FAIL retarget_final: got %0d required 15", duty_cycle); end
        check_drained("retarget");
        n_cmp++;
        if (en_cycles.size() == 0 || en_cycles[0] - acc_cyc != 4) begin
            n_bad++; $display("FAIL retarget_next_step: first strobe not 4 cycles after accept (%0d strobes)", en_cycles.size());
        end
    endtask

    task automatic test_estop();
        do_reset();
        exp_q.push_back(7'd10); exp_q.push_back(7'd20); exp_q.push_back(7'd30); exp_q.push_back(7'd40);
        send_cmd(7'd60, 1'b0, 1'b0);
        wait_duty(7'd40, "estop_prep");
        @(negedge clk);
        e_stop = 1'b1;
        exp_q.push_back(7'd0);
        step();
        n_cmp += 4;
        if (duty_cycle !== 7'd0) begin n_bad++; $display("FAIL estop_duty: got %0d required 0", duty_cycle); end
        if (en !== 1'b1)         begin n_bad++; $display("FAIL estop_en: got %b required 1", en); end
        if (busy !== 1'b0)       begin n_bad++; $display("FAIL estop_busy: got %b required 0", busy); end
        if (cmd_ready !== 1'b0)  begin n_bad++; $display("FAIL estop_ready: got %b required 0", cmd_ready); end
        @(negedge clk);
        cmd_duty = 7'd50; cmd_dir = 1'b0; cmd_valid = 1'b1;
        repeat (3) step();
        n_cmp += 2;
        if (busy !== 1'b0)      begin n_bad++; $display("FAIL estop_ignore_cmd: busy=%b required 0", busy); end
        if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL estop_ready_hold: got %b required 0", cmd_ready); end
        @(negedge clk);
        cmd_valid = 1'b0; e_stop = 1'b0;
        repeat (10) step();
        n_cmp += 3;
        if (cmd_ready !== 1'b1)  begin n_bad++; $display("FAIL estop_release_ready: got %b required 1", cmd_ready); end
        if (busy !== 1'b0)       begin n_bad++; $display("FAIL estop_release_busy: got %b required 0", busy); end
        if (duty_cycle !== 7'd0) begin n_bad++; $display("FAIL estop_release_duty: got %0d required 0", duty_cycle); end
        check_drained("estop");
    endtask

    task automatic test_clr_dead();
        en_cycles.delete();
        send_cmd(7'd0, 1'b1, 1'b0);
        wait_idle("zero_reverse");
        n_cmp += 2;
        if (dir !== 1'b1)          begin n_bad++; $display("FAIL zero_reverse_dir: got %b required 1", dir); end
        if (en_cycles.size() != 0) begin n_bad++; $display("FAIL zero_reverse_en: got %0d strobes required 0", en_cycles.size()); end
        send_cmd(7'd40, 1'b0, 1'b0);
        repeat (6) step();
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL clr_dead_busy: got %b required 1", busy); end
        @(negedge clk);
        clr = 1'b1;
        step();
        n_cmp += 5;
        if (duty_cycle !== 7'd0) begin n_bad++; $display("FAIL clr_dead_duty: got %0d required 0", duty_cycle); end
        if (dir !== 1'b0)        begin n_bad++; $display("FAIL clr_dead_dir: got %b required 0", dir); end
        if (en !== 1'b0)         begin n_bad++; $display("FAIL clr_dead_en: got %b required 0", en); end
        if (cmd_ready !== 1'b1)  begin n_bad++; $display("FAIL clr_dead_ready: got %b required 1", cmd_ready); end
        if (busy !== 1'b0)       begin n_bad++; $display("FAIL clr_dead_busy_low: got %b required 0", busy); end
        @(negedge clk);
        clr = 1'b0;
        repeat (14) step();
        n_cmp += 2;
        if (dir !== 1'b0)  begin n_bad++; $display("FAIL clr_dead_dir_hold: got %b required 0", dir); end
        if (busy !== 1'b0) begin n_bad++; $display("FAIL clr_dead_idle_hold: got %b required 0", busy); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ramp_up();
        test_clamp_noop();
        test_reversal();
        test_retarget();
        test_estop();
        test_clr_dead();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
